lvds_tx_sequencer: RTL and testbench

Sequences the four HSMC LVDS transmit lanes (HSMC_TX_p[3:0]). It takes parallel words from an upstream source over a valid/ready handshake and generates the lane bit clock from the 50 MHz board oscillator. Each transmit session opens with a fixed training preamble, then serialises the words MSB-first on all four lanes in lockstep. It sits between the pattern/data sources and the top-level HSMC pins, and exports a 2-bit state for the board LEDs.

---
 rtl/lvds_pkg.sv | 28 ++
 rtl/lvds_bit_tick.sv | 38 +++
 rtl/lvds_tx_sequencer.sv | 171 +++++++++++++++++
 tb/tb_lvds_tx_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// lvds_pkg: definitions shared by the HSMC LVDS transmit sequencer files.
//   lvds_state_e       - 2-bit session state, also exported on the LED pins
//   LANES              - number of transmit lanes driven in lockstep
//   TRAIN_PAT_DEFAULT  - default training word sent on every lane
//   PRBS7_SEEDS        - per-lane PRBS7 seeds, lane n at [n*7 +: 7]
//   prbs7_next         - one step of the x^7+x^6+1 generator; new bit lands in [0]
package lvds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } lvds_state_e;

  localparam int LANES = 4;

  localparam logic [7:0] TRAIN_PAT_DEFAULT = 8'hF0;

  localparam logic [LANES*7-1:0] PRBS7_SEEDS = {7'h0F, 7'h1F, 7'h3F, 7'h7F};

  // s[6] is the oldest bit; the feedback s[6]^s[5] is both the output bit and
  // the bit shifted in.
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage

// File: rtl/lvds_bit_tick.sv
// lvds_bit_tick: lane bit-rate prescaler.
//   clk, rst_n - oscillator clock, asynchronous active-low reset
//   run        - session continues into the next cycle; when low the counter
//                is forced to 0, when high it counts DIV-1 down to 0 and reloads
//   active     - a session is in progress (state is not IDLE)
//   bit_tick   - counter at 0 while active: last cycle of the current bit
module lvds_bit_tick #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic active,
  output logic bit_tick
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] RELOAD = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  // Leaving IDLE the counter sits at 0, so the zero-reload branch also gives
  // the DIV-1 start value on the session's first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bit_tick = active && (cnt == '0);

endmodule

// File: rtl/lvds_tx_sequencer.sv
// lvds_tx_sequencer: drives the four HSMC LVDS transmit lanes.
// A session opens with TRAIN_WORDS copies of TRAIN_PAT, then serialises
// upstream words MSB-first on all lanes in lockstep, one bit every DIV cycles.
//   OSC_50_B8A  - 50 MHz oscillator, the only clock
//   RESET_n     - asynchronous active-low reset
//   en          - session enable (level, synchronised)
//   word_data   - lane n word at [n*WORD_W +: WORD_W]
//   word_valid  - word_data holds a word
//   word_ready  - a word is taken this cycle if word_valid is also high
//   tx          - lane bits (shifter MSBs)
//   state_o     - 0 IDLE, 1 TRAIN, 2 RUN, 3 DRAIN
//   underrun    - sticky missed-word flag, cleared when a new session starts
// Handshake: word_ready is high for exactly one cycle per word slot (the last
// cycle of a word); the word transfers on that edge when word_valid is high,
// otherwise the fill word goes out and underrun sets. The source holds
// word_valid/word_data stable until it sees word_ready.
// Build option: define LVDS_TX_PRBS_EN to take the fill word from per-lane
// PRBS7 generators; otherwise the fill word is all zeros.
module lvds_tx_sequencer
  import lvds_pkg::*;
#(
  parameter int                DIV         = 50,
  parameter int                WORD_W      = 8,
  parameter int                TRAIN_WORDS = 4,
  parameter logic [WORD_W-1:0] TRAIN_PAT   = WORD_W'(TRAIN_PAT_DEFAULT)
) (
  input  logic                    OSC_50_B8A,
  input  logic                    RESET_n,
  input  logic                    en,
  input  logic [LANES*WORD_W-1:0] word_data,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [LANES-1:0]        tx,
  output logic [1:0]              state_o,
  output logic                    underrun
);

  localparam int BW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam int TW = (TRAIN_WORDS > 2) ? $clog2(TRAIN_WORDS) : 1;
  localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_W - 1);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_WORDS - 1);

  lvds_state_e       state;
  logic [WORD_W-1:0] shreg [LANES];
  logic [WORD_W-1:0] fill  [LANES];
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     train_cnt;
  logic              bit_tick;
  logic              word_end;
  logic              last_train;
  logic              active;
  logic              session_end;
  logic              presc_run;
  logic              miss;

  assign active      = (state != ST_IDLE);
  assign word_end    = bit_tick && (bit_cnt == BIT_LAST);
  assign last_train  = (train_cnt == TRAIN_LAST);
  // Word slots: end of every RUN word, plus the end of the final training
  // word. A low en at the slot closes the session instead of taking a word.
  assign word_ready  = word_end && en &&
                       ((state == ST_RUN) || ((state == ST_TRAIN) && last_train));
  assign miss        = word_ready && !word_valid;
  assign session_end = (state == ST_DRAIN) || ((state == ST_RUN) && word_end && !en);
  assign presc_run   = (state == ST_IDLE) ? en : !session_end;

  lvds_bit_tick #(.DIV(DIV)) u_bit_tick (
    .clk      (OSC_50_B8A),
    .rst_n    (RESET_n),
    .run      (presc_run),
    .active   (active),
    .bit_tick (bit_tick)
  );

  always_comb begin
    for (int n = 0; n < LANES; n++) tx[n] = shreg[n][WORD_W-1];
  end

  assign state_o = state;

  // Later assignments win: shift, then state-driven loads/clears, then the
  // upstream word (or fill) on a word slot.
  always_ff @(posedge OSC_50_B8A or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      train_cnt <= '0;
      underrun  <= 1'b0;
      for (int n = 0; n < LANES; n++) shreg[n] <= '0;
    end else begin
      if (bit_tick) begin
        bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
        for (int n = 0; n < LANES; n++) shreg[n] <= shreg[n] << 1;
      end

      case (state)
        ST_IDLE: begin
          if (en) begin
            state     <= ST_TRAIN;
            bit_cnt   <= '0;
            train_cnt <= '0;
            underrun  <= 1'b0;
            for (int n = 0; n < LANES; n++) shreg[n] <= TRAIN_PAT;
          end
        end
        ST_TRAIN: begin
          if (word_end) begin
            if (!last_train) begin
              train_cnt <= train_cnt + 1'b1;
              for (int n = 0; n < LANES; n++) shreg[n] <= TRAIN_PAT;
            end else if (en) begin
              state <= ST_RUN;
            end else begin
              state <= ST_DRAIN;
              for (int n = 0; n < LANES; n++) shreg[n] <= '0;
            end
          end
        end
        ST_RUN: begin
          if (word_end && !en) begin
            state <= ST_IDLE;
            for (int n = 0; n < LANES; n++) shreg[n] <= '0;
          end
        end
        ST_DRAIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (word_ready) begin
        for (int n = 0; n < LANES; n++)
          shreg[n] <= word_valid ? word_data[n*WORD_W +: WORD_W] : fill[n];
        if (!word_valid) underrun <= 1'b1;
      end
    end
  end

`ifdef LVDS_TX_PRBS_EN
  logic [6:0] prbs     [LANES];
  logic [6:0] prbs_adv [LANES];

  // The first generated bit becomes the fill word's MSB; the generator then
  // rests at the state reached after WORD_W steps.
  always_comb begin
    for (int n = 0; n < LANES; n++) begin
      prbs_adv[n] = prbs[n];
      fill[n]     = '0;
      for (int b = WORD_W - 1; b >= 0; b--) begin
        prbs_adv[n] = prbs7_next(prbs_adv[n]);
        fill[n][b]  = prbs_adv[n][0];
      end
    end
  end

  always_ff @(posedge OSC_50_B8A or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int n = 0; n < LANES; n++) prbs[n] <= PRBS7_SEEDS[n*7 +: 7];
    end else if (miss) begin
      for (int n = 0; n < LANES; n++) prbs[n] <= prbs_adv[n];
    end
  end
`else
  always_comb begin
    for (int n = 0; n < LANES; n++) fill[n] = '0;
  end
`endif

endmodule

// File: tb/tb_lvds_tx_sequencer.sv
// tb_lvds_tx_sequencer: directed sessions with random payload words for
// lvds_tx_sequencer (DIV=4, WORD_W=8, TRAIN_WORDS=2). The expected lane stream
// is built as a list of whole words per session and each cycle's tx, state,
// word_ready and underrun are derived from the cycle index.
module tb_lvds_tx_sequencer;

  localparam int DIV         = 4;
  localparam int WORD_W      = 8;
  localparam int TRAIN_WORDS = 2;
  localparam int LANES       = 4;
  localparam int WORD_CYC    = WORD_W * DIV;
  localparam logic [7:0] TRAIN_PAT = 8'hF0;

  // clock / reset
  logic        clk = 1'b0;
  logic        RESET_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [3:0]  tx;
  logic [1:0]  state_o;
  logic        underrun;

  always #5 clk = ~clk;

  lvds_tx_sequencer #(
    .DIV         (DIV),
    .WORD_W      (WORD_W),
    .TRAIN_WORDS (TRAIN_WORDS),
    .TRAIN_PAT   (TRAIN_PAT)
  ) dut (
    .OSC_50_B8A (clk),
    .RESET_n    (RESET_n),
    .en         (en),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .tx         (tx),
    .state_o    (state_o),
    .underrun   (underrun)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Fill word of the first underrun after reset: zeros, or the first WORD_W
  // bits of each lane's PRBS7 sequence a[i] = a[i-7] ^ a[i-6].
  function automatic logic [31:0] fill_word();
    logic [31:0] w;
    w = '0;
`ifdef LVDS_TX_PRBS_EN
    begin
      logic [27:0] seeds;
      logic        a [0:14];
      seeds = {7'h0F, 7'h1F, 7'h3F, 7'h7F};
      for (int l = 0; l < LANES; l++) begin
        for (int i = 0; i < 7; i++) a[i] = seeds[l*7 + 6 - i];
        for (int i = 7; i < 15; i++) a[i] = a[i-7] ^ a[i-6];
        for (int j = 0; j < 8; j++) w[l*8 + 7 - j] = a[7 + j];
      end
    end
`endif
    return w;
  endfunction

  task automatic check_idle(input string tag, input logic exp_und);
    check({tag, "_tx"}, tx, 32'h0);
    check({tag, "_state"}, state_o, 32'd0);
    check({tag, "_ready"}, word_ready, 32'd0);
    check({tag, "_underrun"}, underrun, exp_und);
  endtask

  // driver: one session starting at the next edge; entered just after a negedge.
  // total_words includes the training words; en drops during bit 3 of the
  // last word. abort_cycle >= 0 asserts reset mid-session at that cycle.
  task automatic run_session(input int total_words, input int miss_slot, input int abort_cycle);
    int n_cyc;
    logic exp_und_end;
    n_cyc = total_words * WORD_CYC;
    exp_q.delete();
    for (int k = 0; k < total_words; k++) begin
      if (k < TRAIN_WORDS)            exp_q.push_back({4{TRAIN_PAT}});
      else if (k == miss_slot)        exp_q.push_back(fill_word());
      else if (k == TRAIN_WORDS)      exp_q.push_back(32'h01FF_3CA5);
      else                            exp_q.push_back($urandom());
    end
    exp_und_end = (miss_slot >= TRAIN_WORDS) && (miss_slot < total_words);
    en = 1'b1;
    word_valid = 1'b0;
    for (int c = 0; c < n_cyc; c++) begin
      int k;
      int b;
      int nxt;
      logic [3:0] exp_tx;
      logic exp_rdy;
      logic exp_und;
      k = c / WORD_CYC;
      b = (c % WORD_CYC) / DIV;
      for (int l = 0; l < LANES; l++) exp_tx[l] = exp_q[k][l*WORD_W + WORD_W - 1 - b];
      exp_rdy = ((c + 1) % WORD_CYC == 0) && ((c + 1) / WORD_CYC >= TRAIN_WORDS) &&
                ((c + 1) / WORD_CYC < total_words);
      exp_und = exp_und_end && (c >= miss_slot * WORD_CYC);
      @(negedge clk);
      check("tx", tx, exp_tx);
      check("state", state_o, (k < TRAIN_WORDS) ? 32'd1 : 32'd2);
      check("word_ready", word_ready, exp_rdy);
      check("underrun", underrun, exp_und);
      if (c == abort_cycle) begin
        #2 RESET_n = 1'b0;
        #1 check_idle("async_reset", 1'b0);
        en = 1'b0;
        word_valid = 1'b0;
        @(negedge clk);
        check_idle("held_reset", 1'b0);
        RESET_n = 1'b1;
        return;
      end
      nxt = k + 1;
      if (nxt < total_words) begin
        word_valid = (nxt != miss_slot);
        word_data  = (nxt == miss_slot) ? 32'hDEAD_BEEF : exp_q[nxt];
      end
      if ((k == total_words - 1) && (b == 3)) en = 1'b0;
    end
    @(negedge clk);
    check_idle("stop", exp_und_end);
  endtask

  // Early stop: en drops during TRAIN, then is raised again during DRAIN.
  task automatic early_stop_session();
    en = 1'b1;
    word_valid = 1'b1;
    word_data = $urandom();
    for (int c = 0; c < TRAIN_WORDS * WORD_CYC; c++) begin
      logic [7:0] pat;
      pat = TRAIN_PAT;
      @(negedge clk);
      check("train_tx", tx, {4{pat[7 - (c % WORD_CYC) / DIV]}});
      check("train_state", state_o, 32'd1);
      check("train_ready", word_ready, 32'd0);
      if (c == 0) check("underrun_cleared", underrun, 32'd0);
      if (c == 10) en = 1'b0;
    end
    @(negedge clk);
    check("drain_state", state_o, 32'd3);
    check("drain_tx", tx, 32'h0);
    check("drain_ready", word_ready, 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("drain_idle_state", state_o, 32'd0);
    check("drain_idle_tx", tx, 32'h0);
    @(negedge clk);
    check("restart_state", state_o, 32'd1);
    check("restart_tx", tx, 32'hF);
    en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle("reset", 1'b0);
    RESET_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset", 1'b0);

    // training, streaming, one underrun, stop mid-word
    run_session(7, 4, -1);
    repeat (3) @(negedge clk);
    check_idle("idle_hold", 1'b1);

    early_stop_session();

    @(negedge clk);
    RESET_n = 1'b0;
    #1 check_idle("reset_pulse", 1'b0);
    @(negedge clk);
    RESET_n = 1'b1;
    @(negedge clk);

    // underrun early in RUN, then asynchronous reset mid-word
    run_session(6, 2, 3 * WORD_CYC + 13);
    repeat (2) @(negedge clk);
    check_idle("after_abort", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
